lfsr_range_rng: RTL and testbench

Parametrised pseudo-random source for game/timing logic: a WIDTH-bit Fibonacci LFSR with a configurable tap mask, runtime reseeding and lock-up recovery. A request/valid handshake delivers values uniformly in [MIN_VALUE, MIN_VALUE+RANGE-1]. Uniformity comes from bounded rejection sampling, not modulo reduction. The block sits between free-running control FSMs (e.g. random delays, random LED or target selection) and the system clock domain.

---
 rtl/lfsr_range_rng.sv | 106 ++++++++++
 tb/tb_lfsr_range_rng.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_range_rng.sv
// Fibonacci LFSR random source with a req/valid handshake. Each value is drawn uniformly from
// [MIN_VALUE, MIN_VALUE+RANGE-1] by bounded rejection sampling.
module lfsr_range_rng #(
  parameter int unsigned     WIDTH     = 10,
  parameter logic [WIDTH-1:0] TAPS     = 10'h240,
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(340),
  parameter int unsigned     MIN_VALUE = 0,
  parameter longint unsigned RANGE     = 18,
  parameter int unsigned     MAX_TRIES = 16,
  parameter int unsigned     OUT_W     = $clog2(MIN_VALUE + RANGE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_value,
  input  logic             req,
  output logic             ready,
  output logic             valid,
  output logic [OUT_W-1:0] value,
  output logic [WIDTH-1:0] lfsr_state
);

  localparam int unsigned RBITS = $clog2(RANGE);
  localparam int unsigned TW    = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;

  localparam logic [RBITS:0]     RANGE_C   = (RBITS + 1)'(RANGE);
  localparam logic [OUT_W-1:0]   MIN_C     = OUT_W'(MIN_VALUE);
  localparam logic [TW-1:0]      TRIES_MAX = TW'(MAX_TRIES);
  localparam logic [WIDTH-1:0]   SEED_INIT = (SEED == '0) ? WIDTH'(1) : SEED;

  typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [TW-1:0]    tries_q;
  logic             ready_q, valid_q;
  logic [OUT_W-1:0] value_q;

  logic [RBITS:0]   cand, cand_wrap;
  logic             cand_ok, give_up;
  logic [OUT_W-1:0] draw_value;

  always_comb begin
    lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    if (seed_load) begin
      lfsr_d = (seed_value == '0) ? WIDTH'(1) : seed_value;
    end else if (lfsr_q == '0) begin
      lfsr_d = WIDTH'(1);
    end
  end

  // The candidate is below 2*RANGE, so one subtraction always lands a rejected value in range.
  always_comb begin
    cand       = {1'b0, lfsr_q[RBITS-1:0]};
    cand_ok    = cand < RANGE_C;
    give_up    = tries_q == TRIES_MAX;
    cand_wrap  = cand - RANGE_C;
    draw_value = OUT_W'(cand_ok ? cand : cand_wrap) + MIN_C;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q  <= SEED_INIT;
      state_q <= StIdle;
      tries_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      value_q <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            state_q <= StDraw;
            tries_q <= '0;
            ready_q <= 1'b0;
          end
        end
        StDraw: begin
          if (cand_ok || give_up) begin
            value_q <= draw_value;
            valid_q <= 1'b1;
            state_q <= StDone;
          end else begin
            tries_q <= tries_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready      = ready_q;
  assign valid      = valid_q;
  assign value      = value_q;
  assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_lfsr_range_rng.sv
// Bench for lfsr_range_rng: directed scenarios on three parameterisations plus a randomized soak
// against a cycle-level reference model built from the draw rules.
module tb_lfsr_range_rng;

  logic       clk = 1'b0;
  logic       reset, seed_load, req;
  logic [9:0] seed_value;
  logic       ready, valid;
  logic [4:0] value;
  logic [9:0] lfsr_state;

  logic       ready_min, valid_min;
  logic [7:0] value_min;
  logic [9:0] lfsr_min;

  logic       req_fb, seed_load_fb;
  logic [9:0] seed_value_fb;
  logic       ready_fb, valid_fb;
  logic [4:0] value_fb;
  logic [9:0] lfsr_fb;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  lfsr_range_rng dut (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_value(seed_value), .req(req),
    .ready(ready), .valid(valid), .value(value), .lfsr_state(lfsr_state)
  );

  lfsr_range_rng #(.MIN_VALUE(200)) dut_min (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_value(seed_value), .req(req),
    .ready(ready_min), .valid(valid_min), .value(value_min), .lfsr_state(lfsr_min)
  );

  lfsr_range_rng #(.RANGE(17), .MAX_TRIES(2)) dut_fb (
    .clk(clk), .reset(reset), .seed_load(seed_load_fb), .seed_value(seed_value_fb),
    .req(req_fb), .ready(ready_fb), .valid(valid_fb), .value(value_fb), .lfsr_state(lfsr_fb)
  );

  // Reference step: shift left, append parity of the tapped bits (x^10+x^7+1).
  function automatic logic [9:0] lfsr_next(input logic [9:0] s);
    int fb;
    fb = $countones(s & 10'h240) % 2;
    return 10'((int'(s) * 2 + fb) % 1024);
  endfunction

  task automatic test_reset();
    reset = 1'b1; seed_load = 1'b0; seed_value = '0; req = 1'b0;
    req_fb = 1'b0; seed_load_fb = 1'b0; seed_value_fb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (lfsr_state !== 10'd340) begin
      tests_failed++; $display("FAIL reset_lfsr: got %0d expected 340", lfsr_state);
    end
    tests_run++;
    if (ready !== 1'b1 || valid !== 1'b0 || value !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ready=%b valid=%b value=%0d expected 1 0 0",
               ready, valid, value);
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (lfsr_state !== 10'd681) begin
      tests_failed++; $display("FAIL reset_step1: got %0d expected 681", lfsr_state);
    end
    @(negedge clk);
    tests_run++;
    if (lfsr_state !== 10'd339) begin
      tests_failed++; $display("FAIL reset_step2: got %0d expected 339", lfsr_state);
    end
  endtask

  task automatic test_first_draw();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++; $display("FAIL first_early_valid: got %b expected 0", valid);
    end
    @(negedge clk);
    tests_run++;
    if (valid !== 1'b1 || value !== 5'd9) begin
      tests_failed++; $display("FAIL first_draw: got valid=%b value=%0d expected 1 9", valid, value);
    end
    tests_run++;
    if (valid_min !== 1'b1 || value_min !== 8'd209) begin
      tests_failed++;
      $display("FAIL first_draw_min: got valid=%b value=%0d expected 1 209", valid_min, value_min);
    end
    @(negedge clk);
    tests_run++;
    if (valid !== 1'b0 || ready !== 1'b1 || value !== 5'd9) begin
      tests_failed++;
      $display("FAIL first_after: got valid=%b ready=%b value=%0d expected 0 1 9",
               valid, ready, value);
    end
  endtask

  task automatic test_rejection();
    seed_load = 1'b1; seed_value = 10'd338;
    @(negedge clk);
    seed_load = 1'b0;
    tests_run++;
    if (lfsr_state !== 10'd338) begin
      tests_failed++; $display("FAIL rej_seed: got %0d expected 338", lfsr_state);
    end
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (valid !== 1'b1 || value !== 5'd5 || value_min !== 8'd205) begin
      tests_failed++;
      $display("FAIL rej_draw: got valid=%b value=%0d min=%0d expected 1 5 205",
               valid, value, value_min);
    end
    @(negedge clk);
  endtask

  task automatic test_seeding();
    int  period;
    bit  zero_seen;
    seed_load = 1'b1; seed_value = 10'd0;
    @(negedge clk);
    seed_load = 1'b0;
    tests_run++;
    if (lfsr_state !== 10'd1) begin
      tests_failed++; $display("FAIL seed_zero: got %0d expected 1", lfsr_state);
    end
    period = 0; zero_seen = 1'b0;
    do begin
      @(negedge clk);
      period++;
      if (lfsr_state === 10'd0) zero_seen = 1'b1;
    end while (lfsr_state !== 10'd1 && period < 1100);
    tests_run++;
    if (period != 1023) begin
      tests_failed++; $display("FAIL seed_period: got %0d expected 1023", period);
    end
    tests_run++;
    if (zero_seen) begin
      tests_failed++; $display("FAIL seed_zero_state: got zero_seen=1 expected 0");
    end
  endtask

  task automatic test_fallback();
    int n;
    tests_run++;
    if (ready_fb !== 1'b1) begin
      tests_failed++; $display("FAIL fb_ready: got %b expected 1", ready_fb);
    end
    req_fb = 1'b1; seed_load_fb = 1'b1; seed_value_fb = 10'd31;
    @(negedge clk);
    req_fb = 1'b0; seed_load_fb = 1'b0;
    n = 1;
    tests_run++;
    if (lfsr_fb !== 10'd31) begin
      tests_failed++; $display("FAIL fb_seed: got %0d expected 31", lfsr_fb);
    end
    while (valid_fb !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n != 4) begin
      tests_failed++; $display("FAIL fb_latency: got %0d expected 4", n);
    end
    tests_run++;
    if (value_fb !== 5'd11) begin
      tests_failed++; $display("FAIL fb_value: got %0d expected 11", value_fb);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_draw_reset();
    int pulses;
    req = 1'b1; seed_load = 1'b1; seed_value = 10'd31;
    @(negedge clk);
    req = 1'b0; seed_load = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ready !== 1'b0 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL middraw_busy: got ready=%b valid=%b expected 0 0", ready, valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (ready !== 1'b1 || lfsr_state !== 10'd340) begin
      tests_failed++;
      $display("FAIL middraw_reset: got ready=%b lfsr=%0d expected 1 340", ready, lfsr_state);
    end
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++; $display("FAIL middraw_novalid: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    int last, pulses;
    last = -1; pulses = 0;
    req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        pulses++;
        if (last >= 0) begin
          tests_run++;
          if (i - last < 3) begin
            tests_failed++; $display("FAIL b2b_spacing: got %0d expected >=3", i - last);
          end
        end
        last = i;
      end
    end
    req = 1'b0;
    tests_run++;
    if (pulses < 2) begin
      tests_failed++; $display("FAIL b2b_count: got %0d expected >=2", pulses);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_soak();
    logic [9:0] m_lfsr;
    logic [4:0] m_value;
    logic [7:0] m_vmin;
    bit         m_ready, m_valid, m_draw, nv;
    int         cands[$];
    int         c, acc, cyc, req_cyc, nreq, lat;
    reset = 1'b1; req = 1'b0; seed_load = 1'b0;
    @(negedge clk);
    m_lfsr = 10'd340; m_value = '0; m_vmin = '0;
    m_ready = 1'b1; m_valid = 1'b0; m_draw = 1'b0;
    cyc = 0; req_cyc = 0; nreq = 0;
    while (nreq < 10000 && cyc < 60000) begin
      tests_run++;
      if (lfsr_state !== m_lfsr) begin
        tests_failed++;
        $display("FAIL soak_lfsr cyc %0d: got %0d expected %0d", cyc, lfsr_state, m_lfsr);
      end
      tests_run++;
      if (ready !== m_ready || valid !== m_valid) begin
        tests_failed++;
        $display("FAIL soak_handshake cyc %0d: got ready=%b valid=%b expected %b %b",
                 cyc, ready, valid, m_ready, m_valid);
      end
      tests_run++;
      if (value !== m_value || value_min !== m_vmin) begin
        tests_failed++;
        $display("FAIL soak_value cyc %0d: got %0d/%0d expected %0d/%0d",
                 cyc, value, value_min, m_value, m_vmin);
      end
      if (valid === 1'b1) begin
        lat = cyc - req_cyc;
        tests_run++;
        if (lat < 2 || lat > 18) begin
          tests_failed++; $display("FAIL soak_latency cyc %0d: got %0d expected 2..18", cyc, lat);
        end
      end

      reset      = ($urandom_range(0, 499) == 0);
      seed_load  = ($urandom_range(0, 19) == 0);
      seed_value = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(0, 1023));
      req        = ($urandom_range(0, 7) != 0);

      if (reset) begin
        m_lfsr = 10'd340; m_value = '0; m_vmin = '0;
        m_ready = 1'b1; m_valid = 1'b0; m_draw = 1'b0;
      end else begin
        nv = 1'b0;
        if (m_valid) begin
          m_ready = 1'b1;
        end else if (m_draw) begin
          // First in-range candidate wins; after 16 rejections the 17th is folded down.
          cands.push_back(int'(m_lfsr) % 32);
          c = cands[$];
          acc = 0;
          if (c < 18) begin
            acc = c; nv = 1'b1;
          end else if (cands.size() == 17) begin
            acc = c - 18; nv = 1'b1;
          end
          if (nv) begin
            m_value = 5'(acc); m_vmin = 8'(acc + 200); m_draw = 1'b0;
          end
        end else if (m_ready && req) begin
          m_draw = 1'b1; m_ready = 1'b0; cands.delete(); req_cyc = cyc; nreq++;
        end
        if (seed_load) m_lfsr = (seed_value == 10'd0) ? 10'd1 : seed_value;
        else m_lfsr = (m_lfsr == 10'd0) ? 10'd1 : lfsr_next(m_lfsr);
        m_valid = nv;
      end
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if (nreq < 10000) begin
      tests_failed++; $display("FAIL soak_budget: got %0d requests expected 10000", nreq);
    end
    reset = 1'b0; req = 1'b0; seed_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_draw();
    test_rejection();
    test_seeding();
    test_fallback();
    test_mid_draw_reset();
    test_back_to_back();
    test_soak();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
